// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// master drives requests and data; slave returns data and status.
interface fifo_sync_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic             clear_err;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wr, data_in, rd, clear_err,
        input  data_out, rd_valid, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  flush, wr, data_in, rd, clear_err,
        output data_out, rd_valid, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with flush, thresholds and
// sticky error flags. Status decodes from the count register only.
module fifo_sync_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input logic              clock,
    input logic              reset,
    fifo_sync_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             full, empty;
    logic             rd_ok, wr_ok;
    logic             do_rd, do_wr;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Accept decisions use only registered occupancy.
    assign rd_ok = bus.rd && !empty;
    assign wr_ok = bus.wr && (!full || rd_ok);
    assign do_rd = rd_ok && !bus.flush;
    assign do_wr = wr_ok && !bus.flush;

    // Next-state for pointers, count, read data and error flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        ovf_d = (ovf_q && !bus.clear_err) ||
                (bus.wr && !wr_ok && !bus.flush);
        udf_d = (udf_q && !bus.clear_err) ||
                (bus.rd && !rd_ok && !bus.flush);
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0
                         : wr_ptr_q + PW'(1);
            end
            if (do_rd) begin
                rd_ptr_d   = (rd_ptr_q == PTR_LAST) ? '0
                           : rd_ptr_q + PW'(1);
                data_out_d = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output registers, cleared by async reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: a DEPTH=4 and a DEPTH=5
// instance, each shadowed by a queue model of its contents.
module tb_fifo_sync_param;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    fifo_sync_param_if #(.WIDTH(32), .DEPTH(4)) b4 ();
    fifo_sync_param_if #(.WIDTH(32), .DEPTH(5)) b5 ();

    fifo_sync_param #(.WIDTH(32), .DEPTH(4)) u4 (
        .clock(clock),
        .reset(reset),
        .bus  (b4.slave)
    );

    fifo_sync_param #(.WIDTH(32), .DEPTH(5)) u5 (
        .clock(clock),
        .reset(reset),
        .bus  (b5.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m4[$];
    logic [31:0] e4[$];
    logic [31:0] m5[$];
    logic [31:0] e5[$];
    logic        ovf4 = 0, udf4 = 0, rv4 = 0;
    logic        rv5 = 0;
    logic [31:0] last4 = 0;

    // One cycle on the DEPTH=4 instance; model updated from pre-edge state.
    task automatic drive4(input logic w, input logic [31:0] d,
                          input logic r, input logic f,
                          input logic c);
        bit fm, em, rok, wok;
        @(negedge clock);
        fm  = (m4.size() == 4);
        em  = (m4.size() == 0);
        rok = r && !em;
        wok = w && (!fm || rok);
        ovf4 = (ovf4 && !c) || (w && !wok && !f);
        udf4 = (udf4 && !c) || (r && !rok && !f);
        if (f) begin
            m4.delete();
            rv4 = 0;
        end else begin
            rv4 = rok;
            if (rok) e4.push_back(m4.pop_front());
            if (wok) m4.push_back(d);
        end
        b4.wr = w; b4.data_in = d; b4.rd = r;
        b4.flush = f; b4.clear_err = c;
        @(posedge clock);
        #1;
        b4.wr = 0; b4.rd = 0; b4.flush = 0; b4.clear_err = 0;
    endtask

    // One cycle on the DEPTH=5 instance.
    task automatic drive5(input logic w, input logic [31:0] d,
                          input logic r);
        bit fm, em, rok, wok;
        @(negedge clock);
        fm  = (m5.size() == 5);
        em  = (m5.size() == 0);
        rok = r && !em;
        wok = w && (!fm || rok);
        rv5 = rok;
        if (rok) e5.push_back(m5.pop_front());
        if (wok) m5.push_back(d);
        b5.wr = w; b5.data_in = d; b5.rd = r;
        b5.flush = 0; b5.clear_err = 0;
        @(posedge clock);
        #1;
        b5.wr = 0; b5.rd = 0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (b4.empty !== 1'b1 || b4.full !== 1'b0 ||
            b4.count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_status: e=%b f=%b c=%0d want 1 0 0",
                     b4.empty, b4.full, b4.count);
        end
        n_chk++;
        if (b4.almost_empty !== 1'b1 || b4.almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_thresh: ae=%b af=%b want 1 0",
                     b4.almost_empty, b4.almost_full);
        end
        n_chk++;
        if (b4.data_out !== 32'h0 || b4.rd_valid !== 1'b0 ||
            b4.overflow !== 1'b0 || b4.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: d=%h v=%b o=%b u=%b want 0",
                     b4.data_out, b4.rd_valid,
                     b4.overflow, b4.underflow);
        end
        n_chk++;
        if (b5.empty !== 1'b1 || b5.count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_d5: e=%b c=%0d want 1 0",
                     b5.empty, b5.count);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [31:0] x;
        for (int i = 0; i < 4; i++) begin
            drive4(1, 32'hA0 + 32'(i), 0, 0, 0);
            n_chk++;
            if (b4.count !== 3'(i + 1) ||
                b4.almost_full !== (i + 1 >= 3) ||
                b4.full !== (i == 3) ||
                b4.almost_empty !== (i + 1 <= 1)) begin
                n_fail++;
                $display("FAIL fill_%0d: c=%0d af=%b f=%b ae=%b",
                         i, b4.count, b4.almost_full,
                         b4.full, b4.almost_empty);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive4(0, 0, 1, 0, 0);
            n_chk++;
            if (b4.rd_valid !== 1'b1 || e4.size() == 0) begin
                n_fail++;
                $display("FAIL drain_valid_%0d: got %b want 1",
                         i, b4.rd_valid);
            end else begin
                x = e4.pop_front();
                last4 = x;
                n_chk++;
                if (b4.data_out !== x) begin
                    n_fail++;
                    $display("FAIL drain_data_%0d: got %h want %h",
                             i, b4.data_out, x);
                end
            end
        end
        n_chk++;
        if (b4.empty !== 1'b1 || b4.count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: e=%b c=%0d want 1 0",
                     b4.empty, b4.count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) drive4(1, 32'hD0 + 32'(i), 0, 0, 0);
        drive4(1, 32'hBB, 0, 0, 0);
        n_chk++;
        if (b4.overflow !== ovf4 || b4.count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set: o=%b c=%0d want %b 4",
                     b4.overflow, b4.count, ovf4);
        end
        drive4(0, 0, 0, 0, 1);
        n_chk++;
        if (b4.overflow !== 1'b0 || b4.overflow !== ovf4) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", b4.overflow);
        end
    endtask

    task automatic test_pass_through();
        logic [31:0] x;
        drive4(1, 32'hCC, 1, 0, 0);
        n_chk++;
        if (b4.rd_valid !== 1'b1 || b4.count !== 3'd4 ||
            e4.size() == 0) begin
            n_fail++;
            $display("FAIL pass_ctl: v=%b c=%0d want 1 4",
                     b4.rd_valid, b4.count);
        end else begin
            x = e4.pop_front();
            last4 = x;
            n_chk++;
            if (b4.data_out !== x) begin
                n_fail++;
                $display("FAIL pass_data: got %h want %h",
                         b4.data_out, x);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive4(0, 0, 1, 0, 0);
            if (e4.size() != 0) begin
                x = e4.pop_front();
                last4 = x;
                n_chk++;
                if (b4.rd_valid !== 1'b1 || b4.data_out !== x) begin
                    n_fail++;
                    $display("FAIL pass_rd_%0d: v=%b d=%h want 1 %h",
                             i, b4.rd_valid, b4.data_out, x);
                end
            end
        end
        n_chk++;
        if (last4 !== 32'hCC || b4.data_out !== 32'hCC) begin
            n_fail++;
            $display("FAIL pass_last: got %h want cc", b4.data_out);
        end
    endtask

    task automatic test_empty_rw();
        logic [31:0] x;
        drive4(1, 32'h11, 1, 0, 0);
        n_chk++;
        if (b4.underflow !== 1'b1 || b4.rd_valid !== 1'b0 ||
            b4.count !== 3'd1) begin
            n_fail++;
            $display("FAIL erw_flags: u=%b v=%b c=%0d want 1 0 1",
                     b4.underflow, b4.rd_valid, b4.count);
        end
        drive4(0, 0, 1, 0, 1);
        n_chk++;
        if (e4.size() == 0) begin
            n_fail++;
            $display("FAIL erw_sb: got empty scoreboard want 1 entry");
        end else begin
            x = e4.pop_front();
            last4 = x;
            if (b4.rd_valid !== 1'b1 || b4.data_out !== x) begin
                n_fail++;
                $display("FAIL erw_rd: v=%b d=%h want 1 %h",
                         b4.rd_valid, b4.data_out, x);
            end
        end
        n_chk++;
        if (b4.underflow !== udf4) begin
            n_fail++;
            $display("FAIL erw_clear: got %b want %b",
                     b4.underflow, udf4);
        end
    endtask

    task automatic test_wrap5();
        logic [31:0] x;
        for (int i = 0; i < 17; i++) begin
            if (i < 12) drive5(1, 32'h500 + 32'(i), i >= 5);
            else drive5(0, 0, 1);
            n_chk++;
            if (b5.count !== 3'(m5.size()) || b5.count > 3'd5 ||
                b5.full !== (m5.size() == 5)) begin
                n_fail++;
                $display("FAIL wrap_cnt_%0d: c=%0d f=%b want %0d",
                         i, b5.count, b5.full, m5.size());
            end
            if (rv5) begin
                x = e5.pop_front();
                n_chk++;
                if (b5.rd_valid !== 1'b1 || b5.data_out !== x) begin
                    n_fail++;
                    $display("FAIL wrap_rd_%0d: v=%b d=%h want 1 %h",
                             i, b5.rd_valid, b5.data_out, x);
                end
            end
        end
        n_chk++;
        if (b5.empty !== 1'b1 || b5.data_out !== 32'h50B) begin
            n_fail++;
            $display("FAIL wrap_end: e=%b d=%h want 1 50b",
                     b5.empty, b5.data_out);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive4(1, 32'hF0 + 32'(i), 0, 0, 0);
        drive4(1, 32'hEE, 0, 1, 0);
        n_chk++;
        if (b4.count !== 3'd0 || b4.empty !== 1'b1 ||
            b4.overflow !== 1'b0 || b4.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ctl: c=%0d e=%b o=%b v=%b",
                     b4.count, b4.empty, b4.overflow, b4.rd_valid);
        end
        n_chk++;
        if (b4.data_out !== last4) begin
            n_fail++;
            $display("FAIL flush_dout: got %h want %h",
                     b4.data_out, last4);
        end
        drive4(1, 32'h77, 0, 0, 0);
        drive4(1, 32'h78, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        n_chk++;
        if (b4.count !== 3'd0 || b4.empty !== 1'b1 ||
            b4.data_out !== 32'h0 || b4.almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst: c=%0d e=%b d=%h ae=%b",
                     b4.count, b4.empty, b4.data_out,
                     b4.almost_empty);
        end
        m4.delete();
        e4.delete();
        ovf4 = 0; udf4 = 0; last4 = 0;
        @(negedge clock);
        reset = 1'b0;
        drive4(0, 0, 1, 0, 0);
        n_chk++;
        if (b4.rd_valid !== 1'b0 || b4.underflow !== udf4) begin
            n_fail++;
            $display("FAIL post_rst_rd: v=%b u=%b want 0 %b",
                     b4.rd_valid, b4.underflow, udf4);
        end
    endtask

    initial begin
        b4.wr = 0; b4.rd = 0; b4.flush = 0;
        b4.clear_err = 0; b4.data_in = 0;
        b5.wr = 0; b5.rd = 0; b5.flush = 0;
        b5.clear_err = 0; b5.data_in = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_pass_through();
        test_empty_rw();
        test_wrap5();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO. It replaces the fixed 4-entry, 32-bit queue in the packet datapath and adds:
- configurable width and depth
- simultaneous read and write in one cycle
- almost-full and almost-empty thresholds
- occupancy count
- synchronous flush
- sticky overflow/underflow error flags
It sits between packet producers and consumers in the same clock domain.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; need not be a power of two)
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
CW = $clog2(DEPTH+1), derived local parameter: count width

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset; one clock; reset is asynchronous and active-high
flush  input  1  synchronous empty request, single-cycle pulse
wr  input  1  write request
data_in  input  WIDTH  write data
rd  input  1  read request
data_out  output  WIDTH  registered read data; holds last value read
rd_valid  output  1  high for one cycle when data_out was updated by an accepted read
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  CW  current occupancy
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected
clear_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async assert, sync-style release):
  - pointers, count, data_out and rd_valid go to 0; overflow and underflow go to 0
  - storage contents are not required to reset
  - resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0)
  - reset mid-operation discards all contents immediately
- Status outputs:
  - full, empty, almost_full and almost_empty decode combinationally from the count register only.
  - They do not depend on same-cycle rd/wr.
- Accept rules, evaluated on the registered state at the clock edge:
  - wr_ok = wr && (!full || rd_ok)
  - rd_ok = rd && !empty
  - Writing when full is accepted only if a read is accepted in the same cycle (pass-through at full).
  - Reading when empty is never accepted, even with a simultaneous write; the write is still accepted.
- Write: mem[wr_ptr] <= data_in; wr_ptr advances.
- Read:
  - data_out <= mem[rd_ptr]; rd_ptr advances; rd_valid=1 on the next cycle.
  - Latency is one clock from rd sample to data_out/rd_valid.
  - rd_valid is 0 on every cycle without an accepted read. data_out holds its value otherwise; it is never tri-stated.
- Pointer wrap: each pointer goes to 0 after DEPTH-1 (explicit compare, not binary rollover).
- Count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
  - It never exceeds DEPTH and never goes below 0.
- Errors:
  - overflow sets on (wr && !wr_ok); underflow sets on (rd && !rd_ok).
  - Both remain set until clear_err.
  - If clear_err coincides with a new error event, the flag stays set (set wins).
- Flush:
  - Synchronous; highest priority after reset.
  - Pointers and count go to 0. Same-cycle rd/wr are ignored and raise no error flags.
  - data_out holds; rd_valid=0 the next cycle; error flags are unchanged.
- Read-after-write: a word written in cycle N is readable from cycle N+1 (empty deasserts at N+1). There is no same-cycle write-to-read bypass when empty.

Test Plan:
1. WIDTH=32, DEPTH=4. Reset, then write 0xA0..0xA3 on 4 cycles -> count 1,2,3,4; full=1 after the 4th; almost_full=1 at count 3. Read 4x -> data_out A0,A1,A2,A3 each one cycle after rd, with rd_valid pulses, then empty=1.
2. When full, assert wr=1 (0xBB) alone -> overflow=1, count stays 4, contents intact. Pulse clear_err -> overflow=0.
3. When full, assert rd=1 and wr=1 (0xCC) together -> data_out=oldest word, count stays 4. After 4 more reads the last word is 0xCC.
4. When empty, assert rd=1 and wr=1 (0x11) together -> underflow=1, rd_valid=0, count=1. The next rd returns 0x11.
5. DEPTH=5 (non-power-of-2). Stream 12 writes/reads interleaved so both pointers wrap twice -> data order preserved, count never exceeds 5.
6. Load 3 words, then pulse flush together with wr=1 -> count=0, empty=1, no overflow, data_out unchanged. Assert reset mid-stream asynchronously -> outputs are at reset values before the next edge.
